// File: rtl/decoder_seq_n.sv
// decoder_seq_n: parametrised SEL_W -> 2**SEL_W one-hot decoder with registered
// outputs and built-in sequencing (direct decode, up/down scan, one-shot sweep).
// out is always the registered decode of index (or all-inactive), so the two
// never disagree.
module decoder_seq_n #(
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned DWELL      = 4,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [SEL_W-1:0]         select,
  input  logic                     load,
  output logic [(1 << SEL_W)-1:0]  out,
  output logic [SEL_W-1:0]         index,
  output logic                     busy,
  output logic                     wrap,
  output logic                     done
);

  localparam int unsigned OUT_W   = 1 << SEL_W;
  localparam int unsigned DWELL_W = 8;

  // Last dwell count before a step; DWELL is limited to 1..255.
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_SWEEP  = 2'b11;

  localparam logic [OUT_W-1:0] ONE_HOT_LSB = OUT_W'(1);
  localparam logic [OUT_W-1:0] OUT_IDLE    = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DIRECT = 2'b01,
    ST_SCAN   = 2'b10,
    ST_SWEEP  = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [SEL_W-1:0]    index_q, index_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic                busy_q, busy_d;
  logic                wrap_q, wrap_d;
  logic                done_q, done_d;
  logic [OUT_W-1:0]    out_q, out_d;

  logic [SEL_W-1:0]    index_up;
  logic [SEL_W-1:0]    index_dn;
  logic                at_top;
  logic                at_bottom;
  logic                dwell_end;
  logic                scan_restart;
  logic [OUT_W-1:0]    one_hot;

  // Neighbour indices wrap modulo 2**SEL_W by construction.
  assign index_up     = index_q + SEL_W'(1);
  assign index_dn     = index_q - SEL_W'(1);
  assign at_top       = (index_q == {SEL_W{1'b1}});
  assign at_bottom    = (index_q == {SEL_W{1'b0}});
  assign dwell_end    = (dwell_q == DWELL_LAST);

  // Scan reloads from select on load, on entry, or on a direction change.
  assign scan_restart = load || (state_q != ST_SCAN) || (mode_q != mode);

  // Next-state, next-index and registered-output computation.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    index_d = index_q;
    dwell_d = dwell_q;
    busy_d  = busy_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;

    if (enable) begin
      mode_d = mode;
      case (mode)
        MODE_DIRECT: begin
          state_d = ST_DIRECT;
          index_d = select;
          dwell_d = '0;
          busy_d  = 1'b0;
        end

        MODE_UP, MODE_DOWN: begin
          state_d = ST_SCAN;
          busy_d  = 1'b0;
          if (scan_restart) begin
            index_d = select;
            dwell_d = '0;
          end else if (dwell_end) begin
            dwell_d = '0;
            if (mode == MODE_UP) begin
              index_d = index_up;
              wrap_d  = at_top;
            end else begin
              index_d = index_dn;
              wrap_d  = at_bottom;
            end
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end

        MODE_SWEEP: begin
          if (load) begin
            state_d = ST_SWEEP;
            index_d = select;
            dwell_d = '0;
            busy_d  = 1'b1;
          end else if (state_q == ST_SWEEP) begin
            if (dwell_end) begin
              dwell_d = '0;
              if (at_top) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                index_d = index_up;
              end
            end else begin
              dwell_d = dwell_q + DWELL_W'(1);
            end
          end else begin
            // Waiting for load; also the landing state when a scan/direct is aborted.
            state_d = ST_IDLE;
            dwell_d = '0;
            busy_d  = 1'b0;
          end
        end

        default: begin
          state_d = ST_IDLE;
          dwell_d = '0;
          busy_d  = 1'b0;
        end
      endcase
    end

    one_hot = ONE_HOT_LSB << index_d;
    if (enable && (state_d != ST_IDLE)) begin
      out_d = (ACTIVE_LOW != 0) ? ~one_hot : one_hot;
    end else begin
      out_d = OUT_IDLE;
    end
  end

  // State, index, dwell and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_DIRECT;
      index_q <= '0;
      dwell_q <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= OUT_IDLE;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      index_q <= index_d;
      dwell_q <= dwell_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign out   = out_q;
  assign index = index_q;
  assign busy  = busy_q;
  assign wrap  = wrap_q;
  assign done  = done_q;

endmodule

// File: tb/tb_decoder_seq_n.sv
// Directed bench for decoder_seq_n: several instances with different DWELL and
// polarity share one stimulus stream; each check targets the relevant instance.
module tb_decoder_seq_n;

  localparam int unsigned SEL_W = 4;
  localparam int unsigned OUT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic [1:0]       mode;
  logic [SEL_W-1:0] select;
  logic             load;

  // DWELL=4, active-high
  logic [OUT_W-1:0] out4;  logic [SEL_W-1:0] idx4;  logic busy4, wrap4, done4;
  // DWELL=2
  logic [OUT_W-1:0] out2;  logic [SEL_W-1:0] idx2;  logic busy2, wrap2, done2;
  // DWELL=1
  logic [OUT_W-1:0] out1;  logic [SEL_W-1:0] idx1;  logic busy1, wrap1, done1;
  // DWELL=3
  logic [OUT_W-1:0] out3;  logic [SEL_W-1:0] idx3;  logic busy3, wrap3, done3;
  // DWELL=4, active-low
  logic [OUT_W-1:0] outl;  logic [SEL_W-1:0] idxl;  logic busyl, wrapl, donel;

  int total = 0;
  int bad   = 0;

  decoder_seq_n #(.SEL_W(SEL_W), .DWELL(4), .ACTIVE_LOW(0)) u_d4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .select(select), .load(load),
    .out(out4), .index(idx4), .busy(busy4), .wrap(wrap4), .done(done4));
  decoder_seq_n #(.SEL_W(SEL_W), .DWELL(2), .ACTIVE_LOW(0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .select(select), .load(load),
    .out(out2), .index(idx2), .busy(busy2), .wrap(wrap2), .done(done2));
  decoder_seq_n #(.SEL_W(SEL_W), .DWELL(1), .ACTIVE_LOW(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .select(select), .load(load),
    .out(out1), .index(idx1), .busy(busy1), .wrap(wrap1), .done(done1));
  decoder_seq_n #(.SEL_W(SEL_W), .DWELL(3), .ACTIVE_LOW(0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .select(select), .load(load),
    .out(out3), .index(idx3), .busy(busy3), .wrap(wrap3), .done(done3));
  decoder_seq_n #(.SEL_W(SEL_W), .DWELL(4), .ACTIVE_LOW(1)) u_al (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .select(select), .load(load),
    .out(outl), .index(idxl), .busy(busyl), .wrap(wrapl), .done(donel));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    mode   = 2'b00;
    select = '0;
    load   = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_out",    32'(out4), 32'h0000);
    check("rst_out_al", 32'(outl), 32'hFFFF);
    check("rst_index",  32'(idx4), 32'd0);
    check("rst_busy",   32'(busy4), 32'd0);
    rst_n = 1'b1;

    // Direct decode, one-cycle latency, both polarities
    mode = 2'b00; select = 4'hA;
    tick();
    check("dir_out",    32'(out4), 32'h0400);
    check("dir_index",  32'(idx4), 32'd10);
    check("dir_out_al", 32'(outl), 32'hFBFF);
    select = 4'h3; load = 1'b1;
    tick();
    load = 1'b0;
    check("dir_out2",   32'(out4), 32'h0008);

    // Scan up, DWELL=2, from 14 with wrap to 0
    mode = 2'b01; select = 4'd14; load = 1'b1;
    tick();
    load = 1'b0;
    check("up_c0_out",  32'(out2), 32'h4000);
    check("up_c0_wrap", 32'(wrap2), 32'd0);
    tick();
    check("up_c1_out",  32'(out2), 32'h4000);
    tick();
    check("up_c2_out",  32'(out2), 32'h8000);
    check("up_c2_wrap", 32'(wrap2), 32'd0);
    tick();
    check("up_c3_out",  32'(out2), 32'h8000);
    tick();
    check("up_c4_out",  32'(out2), 32'h0001);
    check("up_c4_wrap", 32'(wrap2), 32'd1);
    tick();
    check("up_c5_wrap", 32'(wrap2), 32'd0);

    // Scan down, DWELL=1, from 1: 1,0,15,14
    mode = 2'b10; select = 4'd1; load = 1'b1;
    tick();
    load = 1'b0;
    check("dn_i1",      32'(idx1), 32'd1);
    tick();
    check("dn_i0",      32'(idx1), 32'd0);
    check("dn_w0",      32'(wrap1), 32'd0);
    tick();
    check("dn_i15",     32'(idx1), 32'd15);
    check("dn_w15",     32'(wrap1), 32'd1);
    tick();
    check("dn_i14",     32'(idx1), 32'd14);
    check("dn_w14",     32'(wrap1), 32'd0);
    // Load coinciding with a wrapping step: load wins, no wrap
    select = 4'd0; load = 1'b1;
    tick();
    check("ld_i0",      32'(idx1), 32'd0);
    select = 4'd5;
    tick();
    load = 1'b0;
    check("ld_i5",      32'(idx1), 32'd5);
    check("ld_nowrap",  32'(wrap1), 32'd0);

    // Sweep, DWELL=3, from 13: busy 9 cycles, then done
    mode = 2'b11; select = 4'd13; load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k != 0) tick();
      check("sw_index", 32'(idx3), 32'(13 + k / 3));
      check("sw_busy",  32'(busy3), 32'd1);
      check("sw_done",  32'(done3), 32'd0);
    end
    tick();
    check("sw_end_busy", 32'(busy3), 32'd0);
    check("sw_end_done", 32'(done3), 32'd1);
    check("sw_end_out",  32'(out3), 32'h0000);
    check("sw_end_wrap", 32'(wrap3), 32'd0);
    tick();
    check("sw_done_pulse", 32'(done3), 32'd0);

    // Async reset mid-sweep, DWELL=4 at index 7
    mode = 2'b11; select = 4'd7; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    check("pre_rst_index", 32'(idx4), 32'd7);
    check("pre_rst_out",   32'(out4), 32'h0080);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out",   32'(out4), 32'h0000);
    check("mid_rst_busy",  32'(busy4), 32'd0);
    check("mid_rst_index", 32'(idx4), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_busy", 32'(busy4), 32'd0);
    check("post_rst_out",  32'(out4), 32'h0000);
    check("post_rst_idx",  32'(idx4), 32'd0);

    // Enable gating during scan at index 5
    mode = 2'b01; select = 4'd5; load = 1'b1;
    tick();
    load = 1'b0;
    check("en_pre_out",  32'(out4), 32'h0020);
    enable = 1'b0;
    tick();
    check("en_off_out",  32'(out4), 32'h0000);
    check("en_off_idx",  32'(idx4), 32'd5);
    tick();
    tick();
    check("en_off3_out", 32'(out4), 32'h0000);
    check("en_off3_idx", 32'(idx4), 32'd5);
    check("en_off_al",   32'(outl), 32'hFFFF);
    enable = 1'b1;
    tick();
    check("en_on_out",   32'(out4), 32'h0020);
    check("en_on_idx",   32'(idx4), 32'd5);
    tick();
    tick();
    check("en_hold_idx", 32'(idx4), 32'd5);
    tick();
    check("en_step_idx", 32'(idx4), 32'd6);

    // Abort a sweep by switching to direct mode
    mode = 2'b11; select = 4'd3; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("ab_busy_on",  32'(busy4), 32'd1);
    mode = 2'b00; select = 4'd2;
    tick();
    check("ab_busy_off", 32'(busy4), 32'd0);
    check("ab_out",      32'(out4), 32'h0004);
    for (int k = 0; k < 4; k++) begin
      check("ab_no_done", 32'(done4), 32'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
